// File: rtl/fibo_seq_engine_if.sv
// fibo_seq_engine_if: request/result handshake bundle for fibo_seq_engine
// master (requester): drives start_valid, seed0, seed1, order, abort, res_ready
// slave (engine): drives start_ready, res_valid, result, overflow, err
// FIBO_STREAM_EN adds term_valid, term_data, term_index driven by the slave
interface fibo_seq_engine_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ORDER_WIDTH = 16
);
  logic start_valid;
  logic start_ready;
  logic [DATA_WIDTH-1:0] seed0;
  logic [DATA_WIDTH-1:0] seed1;
  logic [ORDER_WIDTH-1:0] order;
  logic abort;
  logic res_valid;
  logic res_ready;
  logic [DATA_WIDTH-1:0] result;
  logic overflow;
  logic err;
`ifdef FIBO_STREAM_EN
  logic term_valid;
  logic [DATA_WIDTH-1:0] term_data;
  logic [ORDER_WIDTH-1:0] term_index;
`endif
  modport master (
`ifdef FIBO_STREAM_EN
    input term_valid, term_data, term_index,
`endif
    output start_valid, seed0, seed1, order, abort, res_ready,
    input start_ready, res_valid, result, overflow, err
  );
  modport slave (
`ifdef FIBO_STREAM_EN
    output term_valid, term_data, term_index,
`endif
    input start_valid, seed0, seed1, order, abort, res_ready,
    output start_ready, res_valid, result, overflow, err
  );
endinterface

// File: rtl/fibo_seq_engine.sv
// fibo_seq_engine: computes T(n) of T(1)=seed0, T(2)=seed1, T(k)=T(k-1)+T(k-2)
// ports: clk, rst_n (async active-low), bus (fibo_seq_engine_if.slave)
// request accepted on start_valid & start_ready; result held in DONE until res_ready or abort
// result is all-ones with overflow=1 on carry-out, 0 with err=1 for order==0
// FIBO_STREAM_EN: also pulses term_valid with term_data/term_index for every computed term
module fibo_seq_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int ORDER_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  fibo_seq_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d, cur_q, cur_d, result_q, result_d;
  logic [ORDER_WIDTH-1:0] k_q, k_d, n_q, n_d;
  logic overflow_q, overflow_d, err_q, err_d;
  logic [DATA_WIDTH:0] sum;
  logic last;
  assign sum = {1'b0, prev_q} + {1'b0, cur_q};
  // widened compare so k+1 cannot wrap when n sits at the top of the order range
  assign last = ({1'b0, k_q} + (ORDER_WIDTH+1)'(1)) == {1'b0, n_q};
`ifdef FIBO_STREAM_EN
  logic term_valid_q, term_valid_d;
  logic [DATA_WIDTH-1:0] term_data_q, term_data_d;
  logic [ORDER_WIDTH-1:0] term_index_q, term_index_d;
`endif
  always_comb begin
    state_d = state_q;
    prev_d = prev_q;
    cur_d = cur_q;
    k_d = k_q;
    n_d = n_q;
    result_d = result_q;
    overflow_d = overflow_q;
    err_d = err_q;
`ifdef FIBO_STREAM_EN
    term_valid_d = 1'b0;
    term_data_d = term_data_q;
    term_index_d = term_index_q;
`endif
    unique case (state_q)
      IDLE: if (bus.start_valid) begin
        n_d = bus.order;
        prev_d = bus.seed0;
        cur_d = bus.seed1;
        k_d = ORDER_WIDTH'(2);
        overflow_d = 1'b0;
        err_d = bus.order == '0;
        result_d = bus.order == ORDER_WIDTH'(1) ? bus.seed0 :
                   bus.order == ORDER_WIDTH'(2) ? bus.seed1 : '0;
        state_d = bus.order >= ORDER_WIDTH'(3) ? CALC : DONE;
      end
      CALC: if (bus.abort) state_d = IDLE;
      else if (sum[DATA_WIDTH]) begin
        state_d = DONE;
        result_d = '1;
        overflow_d = 1'b1;
      end else begin
`ifdef FIBO_STREAM_EN
        term_valid_d = 1'b1;
        term_data_d = sum[DATA_WIDTH-1:0];
        term_index_d = k_q + ORDER_WIDTH'(1);
`endif
        if (last) begin
          state_d = DONE;
          result_d = sum[DATA_WIDTH-1:0];
        end else begin
          prev_d = cur_q;
          cur_d = sum[DATA_WIDTH-1:0];
          k_d = k_q + ORDER_WIDTH'(1);
        end
      end
      DONE: state_d = bus.abort || bus.res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q <= '0;
      cur_q <= '0;
      k_q <= '0;
      n_q <= '0;
      result_q <= '0;
      overflow_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      cur_q <= cur_d;
      k_q <= k_d;
      n_q <= n_d;
      result_q <= result_d;
      overflow_q <= overflow_d;
      err_q <= err_d;
    end
  end
`ifdef FIBO_STREAM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_valid_q <= 1'b0;
      term_data_q <= '0;
      term_index_q <= '0;
    end else begin
      term_valid_q <= term_valid_d;
      term_data_q <= term_data_d;
      term_index_q <= term_index_d;
    end
  end
  assign bus.term_valid = term_valid_q;
  assign bus.term_data = term_data_q;
  assign bus.term_index = term_index_q;
`endif
  assign bus.start_ready = state_q == IDLE;
  assign bus.res_valid = state_q == DONE;
  assign bus.result = result_q;
  assign bus.overflow = overflow_q;
  assign bus.err = err_q;
endmodule
